// File: rtl/jtframe_sdram_arb_pkg.sv
// Shared types and helpers for the jtframe SDRAM slot arbiters.
// Contents: arbiter state encoding, grant-index width helper, and the
// round-robin pick function used by jtframe_rr_pick.
//
// rr_pick works on a fixed MAX_SLOT-wide request vector so that one function
// serves every arbiter size. Callers zero-extend their requests and pointer,
// and pass the real slot count in n. The pointer must be below n.
package jtframe_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        DONE = 2'd3
    } arb_state_t;

    localparam int MAX_SLOT = 8;
    localparam int IDX_W    = $clog2(MAX_SLOT);

    typedef struct packed {
        logic             vld;
        logic [IDX_W-1:0] idx;
    } pick_t;

    // A single slot still needs a 1-bit index.
    function automatic int gnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Returns the first set request at or after ptr, wrapping modulo n.
    // The loop scans from the farthest distance down to the nearest one.
    // As a result, the nearest requester is the last match to be written.
    function automatic pick_t rr_pick(input logic [MAX_SLOT-1:0] req,
                                      input logic [IDX_W-1:0]    ptr,
                                      input int                  n);
        pick_t            p;
        int               j;
        logic [IDX_W-1:0] j_idx;
        p = '0;
        for (int i = MAX_SLOT - 1; i >= 0; i--) begin
            j = int'(ptr) + i;
            if (j >= n) begin
                j = j - n;
            end
            j_idx = j[IDX_W-1:0];
            if ((i < n) && (j >= 0) && (j < n) && req[j_idx]) begin
                p.vld = 1'b1;
                p.idx = j_idx;
            end
        end
        return p;
    endfunction

endpackage

// File: rtl/jtframe_sdram_arb_if.sv
// Game-side SDRAM controller port, shared by the slot arbiter and the
// framework SDRAM controller.
// master: arbiter (drives request, address, direction, mask, write data)
// slave : controller (drives ack, read data, data-ready)
interface jtframe_sdram_arb_if #(
    parameter int AW = 22
);
    logic          sdram_req;
    logic          sdram_ack;
    logic [AW-1:0] sdram_addr;
    logic          sdram_rnw;
    logic [1:0]    sdram_wrmask;   // active-low byte mask
    logic [15:0]   data_write;
    logic [31:0]   data_read;
    logic          data_rdy;

    modport master (
        output sdram_req,
        output sdram_addr,
        output sdram_rnw,
        output sdram_wrmask,
        output data_write,
        input  sdram_ack,
        input  data_read,
        input  data_rdy
    );

    modport slave (
        input  sdram_req,
        input  sdram_addr,
        input  sdram_rnw,
        input  sdram_wrmask,
        input  data_write,
        output sdram_ack,
        output data_read,
        output data_rdy
    );
endinterface

// File: rtl/jtframe_rr_pick.sv
// Round-robin priority encoder: first asserted request at or after ptr.
// Ports: req (NSLOT levels), ptr (start index) -> idx (winner), vld (any req).
// Purely combinational, so there is no latency and no backpressure.
module jtframe_rr_pick
    import jtframe_arb_pkg::*;
#(
    parameter int NSLOT = 4,
    parameter int GW    = gnt_w(NSLOT)
) (
    input  logic [NSLOT-1:0] req,
    input  logic [GW-1:0]    ptr,
    output logic [GW-1:0]    idx,
    output logic             vld
);

    logic [MAX_SLOT-1:0] req_x;
    logic [IDX_W-1:0]    ptr_x;
    pick_t               p;

    always_comb begin
        req_x            = '0;
        req_x[NSLOT-1:0] = req;
        ptr_x            = '0;
        ptr_x[GW-1:0]    = ptr;
        p                = rr_pick(req_x, ptr_x, NSLOT);
    end

    assign idx = p.idx[GW-1:0];
    assign vld = p.vld;

endmodule

// File: rtl/jtframe_sdram_arb.sv
// Round-robin arbiter that shares the game SDRAM port among NSLOT slots.
// Inputs: clk, rst, downloading/loop_rst (grant blocking), and per-slot
// req/addr/rnw/wrmask/din.
// Outputs: slot_ok/slot_err (one-cycle pulses), slot_dout, busy, and the
// sdram master port.
//
// Latency: the grant registers on the first edge after slot_req. slot_ok
// rises one cycle after data_rdy.
// Backpressure: slot_req is held until slot_ok. The controller stalls the
// arbiter through sdram_ack and data_rdy.
//
// One transaction is in flight at a time. Address, direction, mask and
// write data are captured on the grant edge. They stay stable until the next
// grant, so slot inputs may change freely once granted.
module jtframe_sdram_arb
    import jtframe_arb_pkg::*;
#(
    parameter int NSLOT = 4,
    parameter int AW    = 22,
    parameter int TOUT  = 255
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                downloading,
    input  logic                loop_rst,

    input  logic [NSLOT-1:0]    slot_req,
    input  logic [NSLOT*AW-1:0] slot_addr,
    input  logic [NSLOT-1:0]    slot_rnw,
    input  logic [NSLOT*2-1:0]  slot_wrmask,
    input  logic [NSLOT*16-1:0] slot_din,
    output logic [NSLOT-1:0]    slot_ok,
    output logic [31:0]         slot_dout,
    output logic [NSLOT-1:0]    slot_err,

    jtframe_sdram_arb_if.master sdram,

    output logic                busy
);

    localparam int GW = gnt_w(NSLOT);
    localparam int CW = (TOUT > 0) ? $clog2(TOUT + 1) : 1;

    arb_state_t        state_q, state_d;
    logic [GW-1:0]     grant_q;
    logic [GW-1:0]     ptr_q;
    logic [CW-1:0]     cnt_q;
    logic [AW-1:0]     addr_q;
    logic              rnw_q;
    logic [1:0]        wrmask_q;
    logic [15:0]       din_q;
    logic [31:0]       dout_q;

    logic [GW-1:0]     pick_idx;
    logic              pick_vld;
    logic              tout_hit;
    logic              grant_now;
    logic [GW-1:0]     ptr_next;
    logic [AW-1:0]     addr_sel;
    logic              rnw_sel;
    logic [1:0]        wrmask_sel;
    logic [15:0]       din_sel;
    logic [NSLOT-1:0]  grant_oh;

    jtframe_rr_pick #(
        .NSLOT (NSLOT),
        .GW    (GW)
    ) u_pick (
        .req   (slot_req),
        .ptr   (ptr_q),
        .idx   (pick_idx),
        .vld   (pick_vld)
    );

    // Route the winning slot's request fields to the capture registers.
    always_comb begin
        addr_sel   = '0;
        rnw_sel    = 1'b0;
        wrmask_sel = '0;
        din_sel    = '0;
        for (int i = 0; i < NSLOT; i++) begin
            if (pick_idx == GW'(i)) begin
                addr_sel   = slot_addr[i*AW +: AW];
                rnw_sel    = slot_rnw[i];
                wrmask_sel = slot_wrmask[i*2 +: 2];
                din_sel    = slot_din[i*16 +: 16];
            end
        end
    end

    // The slot just served, or just timed out, drops to lowest priority.
    assign ptr_next = (grant_q == GW'(NSLOT - 1)) ? '0 : grant_q + GW'(1);
    assign grant_oh = {{(NSLOT-1){1'b0}}, 1'b1} << grant_q;

    // Next-state and pulse outputs
    always_comb begin
        state_d   = state_q;
        tout_hit  = 1'b0;
        grant_now = 1'b0;
        unique case (state_q)
            IDLE: begin
                // The gating inputs only block new grants. A transaction
                // already past IDLE always runs to completion.
                if (!downloading && !loop_rst && pick_vld) begin
                    grant_now = 1'b1;
                    state_d   = REQ;
                end
            end
            REQ: begin
                // data_rdy is ignored here. The controller has not
                // accepted the request yet.
                if (sdram.sdram_ack) begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                // data_rdy wins over a timeout in the same cycle.
                // A stray ack in this state is ignored.
                if (sdram.data_rdy) begin
                    state_d = DONE;
                end else if ((TOUT != 0) && (cnt_q == CW'(TOUT))) begin
                    tout_hit = 1'b1;
                    state_d  = IDLE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, grant, pointer and captured request
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            grant_q  <= '0;
            ptr_q    <= '0;
            cnt_q    <= '0;
            addr_q   <= '0;
            rnw_q    <= 1'b0;
            wrmask_q <= '0;
            din_q    <= '0;
            dout_q   <= '0;
        end else begin
            state_q <= state_d;

            if (grant_now) begin
                grant_q  <= pick_idx;
                addr_q   <= addr_sel;
                rnw_q    <= rnw_sel;
                wrmask_q <= wrmask_sel;
                din_q    <= din_sel;
            end

            // The counter is held clear while waiting for ack. It then
            // counts the cycles spent in WAIT.
            if (state_q == REQ) begin
                cnt_q <= '0;
            end else if (state_q == WAIT) begin
                cnt_q <= cnt_q + CW'(1);
            end

            if ((state_q == WAIT) && sdram.data_rdy) begin
                dout_q <= sdram.data_read;
            end

            if ((state_q == DONE) || tout_hit) begin
                ptr_q <= ptr_next;
            end
        end
    end

    assign slot_ok   = (state_q == DONE) ? grant_oh : '0;
    assign slot_err  = tout_hit ? grant_oh : '0;
    assign slot_dout = dout_q;
    assign busy      = (state_q != IDLE);

    assign sdram.sdram_req    = (state_q == REQ);
    assign sdram.sdram_addr   = addr_q;
    assign sdram.sdram_rnw    = rnw_q;
    assign sdram.sdram_wrmask = wrmask_q;
    assign sdram.data_write   = din_q;

endmodule

// File: tb/tb_jtframe_sdram_arb.sv
module tb_jtframe_sdram_arb;

    localparam int NSLOT = 4;
    localparam int AW    = 22;
    localparam int TOUT  = 16;

    logic                clk = 1'b0;
    logic                rst;
    logic                downloading;
    logic                loop_rst;
    logic [NSLOT-1:0]    slot_req;
    logic [NSLOT*AW-1:0] slot_addr;
    logic [NSLOT-1:0]    slot_rnw;
    logic [NSLOT*2-1:0]  slot_wrmask;
    logic [NSLOT*16-1:0] slot_din;
    logic [NSLOT-1:0]    slot_ok;
    logic [31:0]         slot_dout;
    logic [NSLOT-1:0]    slot_err;
    logic                busy;

    jtframe_sdram_arb_if #(.AW(AW)) sd ();

    jtframe_sdram_arb #(
        .NSLOT       (NSLOT),
        .AW          (AW),
        .TOUT        (TOUT)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .downloading (downloading),
        .loop_rst    (loop_rst),
        .slot_req    (slot_req),
        .slot_addr   (slot_addr),
        .slot_rnw    (slot_rnw),
        .slot_wrmask (slot_wrmask),
        .slot_din    (slot_din),
        .slot_ok     (slot_ok),
        .slot_dout   (slot_dout),
        .slot_err    (slot_err),
        .sdram       (sd),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic set_slot(input int i, input logic [21:0] a, input logic r,
                            input logic [1:0] m, input logic [15:0] d);
        slot_addr[i*AW +: AW]   = a;
        slot_rnw[i]             = r;
        slot_wrmask[i*2 +: 2]   = m;
        slot_din[i*16 +: 16]    = d;
    endtask

    // Plays the controller for one transaction and checks the arbiter.
    // The expected grant s must already have its inputs set and slot_req
    // raised on the current negedge.
    // noise bit0: pulse data_rdy during REQ, before the ack.
    // noise bit1: raise ack together with data_rdy in WAIT.
    // noise bit2: raise downloading during WAIT.
    task automatic txn(input int s, input logic [21:0] a, input logic r,
                       input logic [1:0] m, input logic [15:0] d,
                       input int ack_lat, input int rdy_lat,
                       input logic [31:0] rdata, input int noise);
        int   waits;
        logic seen;
        seen  = 1'b0;
        waits = 0;
        while (!seen && waits < 20) begin
            @(negedge clk);
            waits++;
            if (sd.sdram_req) seen = 1'b1;
        end
        if (!seen) begin
            chk("req_seen", 64'(0), 64'(1));
            return;
        end
        chk("grant_lat", 64'(waits), 64'(1));
        chk("req_addr", 64'(sd.sdram_addr), 64'(a));
        chk("req_rnw", 64'(sd.sdram_rnw), 64'(r));
        chk("req_wrmask", 64'(sd.sdram_wrmask), 64'(m));
        chk("req_wdata", 64'(sd.data_write), 64'(d));
        chk("req_busy", 64'(busy), 64'(1));
        // Granted slot changes its inputs; the latched outputs must not move.
        slot_addr[s*AW +: AW] = ~a;
        slot_din[s*16 +: 16]  = ~d;
        slot_rnw[s]           = ~r;
        if (noise[0]) begin
            sd.data_rdy  = 1'b1;
            sd.data_read = 32'h0BAD0BAD;
        end
        repeat (ack_lat) begin
            @(negedge clk);
            sd.data_rdy = 1'b0;
            chk("req_held", 64'(sd.sdram_req), 64'(1));
        end
        sd.sdram_ack = 1'b1;
        @(negedge clk);
        sd.sdram_ack = 1'b0;
        chk("req_drop", 64'(sd.sdram_req), 64'(0));
        chk("wait_busy", 64'(busy), 64'(1));
        if (noise[2]) downloading = 1'b1;
        repeat (rdy_lat - 1) @(negedge clk);
        sd.data_rdy  = 1'b1;
        sd.data_read = rdata;
        if (noise[1]) sd.sdram_ack = 1'b1;
        chk("hold_addr", 64'(sd.sdram_addr), 64'(a));
        chk("hold_rnw", 64'(sd.sdram_rnw), 64'(r));
        chk("hold_wdata", 64'(sd.data_write), 64'(d));
        chk("no_ok_early", 64'(slot_ok), 64'(0));
        @(negedge clk);
        sd.data_rdy  = 1'b0;
        sd.sdram_ack = 1'b0;
        chk("ok", 64'(slot_ok), 64'(4'b0001 << s));
        chk("dout", 64'(slot_dout), 64'(rdata));
        chk("err_none", 64'(slot_err), 64'(0));
        slot_req[s] = 1'b0;
        @(negedge clk);
        chk("ok_pulse", 64'(slot_ok), 64'(0));
        chk("idle_busy", 64'(busy), 64'(0));
    endtask

    typedef struct {
        logic [3:0]  req;
        int          slot;
        logic [21:0] addr;
        logic        rnw;
        logic [1:0]  wm;
        logic [15:0] din;
        int          ack_lat;
        int          rdy_lat;
        logic [31:0] rdata;
    } vec_t;

    vec_t vecs[10];

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        // Round-robin under full load starting from pointer 0.
        vecs[0] = '{4'hF, 0, 22'h010000, 1'b1, 2'b00, 16'h0000, 1, 2, 32'h11110000};
        vecs[1] = '{4'hF, 1, 22'h010001, 1'b1, 2'b00, 16'h0000, 1, 2, 32'h22221111};
        vecs[2] = '{4'hF, 2, 22'h010002, 1'b1, 2'b00, 16'h0000, 2, 1, 32'h33332222};
        vecs[3] = '{4'hF, 3, 22'h010003, 1'b1, 2'b00, 16'h0000, 1, 3, 32'h44443333};
        vecs[4] = '{4'hF, 0, 22'h010000, 1'b1, 2'b00, 16'h0000, 1, 2, 32'h55554444};
        vecs[5] = '{4'hF, 1, 22'h010001, 1'b1, 2'b00, 16'h0000, 1, 2, 32'h66665555};
        // Single read from slot 2 (pointer is at 2).
        vecs[6] = '{4'h4, 2, 22'h012345, 1'b1, 2'b11, 16'h0000, 2, 5, 32'hDEADBEEF};
        // Write from slot 1.
        vecs[7] = '{4'h2, 1, 22'h000777, 1'b0, 2'b10, 16'hA55A, 1, 3, 32'h00000000};
        // Pointer at 2: slot 3 beats slot 0.
        vecs[8] = '{4'h9, 3, 22'h03FFFF, 1'b1, 2'b01, 16'h1234, 3, 1, 32'hCAFEF00D};
        // Pointer at 0: slot 1 beats slot 3.
        vecs[9] = '{4'hA, 1, 22'h2AAAAA, 1'b1, 2'b00, 16'h4321, 1, 4, 32'h12345678};

        rst          = 1'b1;
        downloading  = 1'b0;
        loop_rst     = 1'b0;
        slot_req     = '0;
        slot_addr    = '0;
        slot_rnw     = '0;
        slot_wrmask  = '0;
        slot_din     = '0;
        sd.sdram_ack = 1'b0;
        sd.data_rdy  = 1'b0;
        sd.data_read = '0;

        repeat (3) @(negedge clk);
        chk("rst_req", 64'(sd.sdram_req), 64'(0));
        chk("rst_busy", 64'(busy), 64'(0));
        chk("rst_ok", 64'(slot_ok), 64'(0));
        chk("rst_err", 64'(slot_err), 64'(0));
        chk("rst_dout", 64'(slot_dout), 64'(0));
        chk("rst_addr", 64'(sd.sdram_addr), 64'(0));
        chk("rst_wdata", 64'(sd.data_write), 64'(0));
        chk("rst_wrmask", 64'(sd.sdram_wrmask), 64'(0));
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 10; i++) begin
            for (int j = 0; j < NSLOT; j++) begin
                set_slot(j, 22'h010000 + 22'(j), 1'b1, 2'b00, 16'h0000);
            end
            set_slot(vecs[i].slot, vecs[i].addr, vecs[i].rnw, vecs[i].wm, vecs[i].din);
            slot_req = vecs[i].req;
            txn(vecs[i].slot, vecs[i].addr, vecs[i].rnw, vecs[i].wm, vecs[i].din,
                vecs[i].ack_lat, vecs[i].rdy_lat, vecs[i].rdata,
                (i == 2) ? 1 : (i == 3) ? 2 : 0);
        end
        slot_req = '0;

        // Gating: downloading, then loop_rst, blocks the grant.
        set_slot(0, 22'h00ABCD, 1'b1, 2'b00, 16'h0000);
        downloading = 1'b1;
        slot_req[0] = 1'b1;
        repeat (4) begin
            @(negedge clk);
            chk("dl_req", 64'(sd.sdram_req), 64'(0));
            chk("dl_busy", 64'(busy), 64'(0));
        end
        downloading = 1'b0;
        loop_rst    = 1'b1;
        repeat (2) begin
            @(negedge clk);
            chk("lr_req", 64'(sd.sdram_req), 64'(0));
        end
        loop_rst = 1'b0;
        txn(0, 22'h00ABCD, 1'b1, 2'b00, 16'h0000, 1, 3, 32'h0F0F0F0F, 4);
        downloading = 1'b0;

        // Timeout: slot 1 gets ack but no rdy; slot 3 waits behind it.
        set_slot(1, 22'h001111, 1'b1, 2'b00, 16'h0000);
        set_slot(3, 22'h003333, 1'b1, 2'b00, 16'h0000);
        slot_req = 4'b1010;
        @(negedge clk);
        chk("to_req", 64'(sd.sdram_req), 64'(1));
        chk("to_addr", 64'(sd.sdram_addr), 64'(22'h001111));
        sd.sdram_ack = 1'b1;
        @(negedge clk);
        sd.sdram_ack = 1'b0;
        for (int k = 1; k <= TOUT; k++) begin
            chk("to_no_err", 64'(slot_err), 64'(0));
            chk("to_busy", 64'(busy), 64'(1));
            @(negedge clk);
        end
        chk("to_err", 64'(slot_err), 64'(4'b0010));
        chk("to_no_ok", 64'(slot_ok), 64'(0));
        slot_req[1] = 1'b0;
        @(negedge clk);
        chk("to_idle", 64'(busy), 64'(0));
        chk("to_err_pulse", 64'(slot_err), 64'(0));
        @(negedge clk);
        chk("to_next_req", 64'(sd.sdram_req), 64'(1));
        chk("to_next_addr", 64'(sd.sdram_addr), 64'(22'h003333));
        sd.sdram_ack = 1'b1;
        @(negedge clk);
        sd.sdram_ack = 1'b0;
        sd.data_rdy  = 1'b1;
        sd.data_read = 32'h55AA55AA;
        @(negedge clk);
        sd.data_rdy = 1'b0;
        chk("to_next_ok", 64'(slot_ok), 64'(4'b1000));
        chk("to_next_dout", 64'(slot_dout), 64'(32'h55AA55AA));
        slot_req[3] = 1'b0;
        @(negedge clk);

        // Reset mid-WAIT. Serve slot 1 first so the pointer sits at 2.
        set_slot(1, 22'h000101, 1'b1, 2'b00, 16'h0000);
        slot_req = 4'b0010;
        txn(1, 22'h000101, 1'b1, 2'b00, 16'h0000, 1, 1, 32'hABCD0001, 0);
        set_slot(3, 22'h0C0C0C, 1'b1, 2'b00, 16'h0000);
        slot_req = 4'b1000;
        @(negedge clk);
        chk("rw_req", 64'(sd.sdram_req), 64'(1));
        sd.sdram_ack = 1'b1;
        @(negedge clk);
        sd.sdram_ack = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rw_req0", 64'(sd.sdram_req), 64'(0));
        chk("rw_ok0", 64'(slot_ok), 64'(0));
        chk("rw_busy0", 64'(busy), 64'(0));
        chk("rw_addr0", 64'(sd.sdram_addr), 64'(0));
        // Pointer back at 0: slot 0 goes before the re-issued slot 3.
        set_slot(0, 22'h000F00, 1'b1, 2'b00, 16'h0000);
        set_slot(3, 22'h0C0C0C, 1'b1, 2'b00, 16'h0000);
        slot_req = 4'b1001;
        txn(0, 22'h000F00, 1'b1, 2'b00, 16'h0000, 1, 2, 32'h00C0FFEE, 0);
        txn(3, 22'h0C0C0C, 1'b1, 2'b00, 16'h0000, 2, 2, 32'hFEEDFACE, 0);
        slot_req = '0;

        repeat (3) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/jtframe_sdram_arb.md
Name: jtframe_sdram_arb

Overview:
- Shares the single game-side SDRAM port (sdram_req/sdram_ack/sdram_addr/data_read/data_rdy plus the write-back signals) among NSLOT requesters inside the game core, e.g. CPU ROM, char, scroll, object and sound.
- Grants one transaction at a time using round-robin priority, sequences the req/ack/rdy handshake, and returns the 32-bit read word to the granted slot.
- Sits between the game's ROM/RAM slots and the framework board's SDRAM controller interface.

Parameters:
- NSLOT, 4, number of requesters (2..8).
- AW, 22, SDRAM word address width.
- TOUT, 255, cycles to wait for data_rdy before abort; 0 disables the timeout.

Ports:
- clk  in  1  system clock, same domain as the SDRAM controller game port.
- rst  in  1  synchronous reset, active-high.
- downloading  in  1  ROM load in progress; blocks all new grants.
- loop_rst  in  1  controller not ready; blocks all new grants.
- slot_req  in  NSLOT  per-slot request level; held until that slot's slot_ok.
- slot_addr  in  NSLOT*AW  per-slot address, slot i at bits [i*AW +: AW].
- slot_rnw  in  NSLOT  1 = read, 0 = write.
- slot_wrmask  in  NSLOT*2  per-slot byte mask (active-low, as the controller expects).
- slot_din  in  NSLOT*16  per-slot write data.
- slot_ok  out  NSLOT  one-cycle completion pulse to the granted slot.
- slot_dout  out  32  read data, common to all slots, valid while slot_ok is high.
- slot_err  out  NSLOT  one-cycle timeout pulse to the granted slot.
- sdram_req  out  1  request to the controller.
- sdram_ack  in  1  controller accepted the request.
- sdram_addr  out  AW  address of the granted slot.
- sdram_rnw  out  1  direction of the granted slot.
- sdram_wrmask  out  2  byte mask of the granted slot.
- data_write  out  16  write data of the granted slot.
- data_read  in  32  read data from the controller.
- data_rdy  in  1  controller says data_read is valid or the write is complete.
- busy  out  1  arbiter is not in IDLE.

Behaviour:
- Reset values: all outputs 0, state IDLE, round-robin pointer = 0, timeout counter = 0.
- States: IDLE, REQ, WAIT, DONE.
- IDLE:
  - If downloading = 0, loop_rst = 0 and any slot_req is high, pick the first requesting slot starting at pointer and wrapping modulo NSLOT.
  - On that cycle, register the grant index and latch that slot's addr, rnw, wrmask and din into the sdram_* outputs. Go to REQ.
- REQ:
  - sdram_req = 1 until the cycle sdram_ack is sampled high.
  - On that cycle: sdram_req goes to 0 on the next edge, go to WAIT, clear the timeout counter.
- WAIT:
  - On data_rdy = 1: latch data_read into slot_dout, go to DONE.
  - The counter increments every WAIT cycle. If TOUT ≠ 0 and counter = TOUT with no data_rdy, pulse slot_err for the granted slot and go to IDLE, setting pointer = grant+1. No slot_ok is issued.
- DONE:
  - slot_ok[grant] = 1 for exactly this cycle.
  - pointer = grant+1 (mod NSLOT). Next state is IDLE.
- Latency: a single uncontested request sees grant → sdram_req on the first edge after slot_req; slot_ok follows one cycle after data_rdy. Minimum request-to-ok is ack latency + rdy latency + 3 cycles.
- Fairness: a slot that was just served has lowest priority next time. Under full load each slot waits at most NSLOT-1 transactions.
- Latched values: the sdram_* address and data outputs hold their latched values from the grant cycle until the next grant. Changes on slot inputs mid-transaction are ignored.
- slot_req dropped mid-transaction: the transaction still completes and slot_ok still pulses; the slot must ignore it.
- data_rdy in REQ, before ack: ignored.
- sdram_ack and data_rdy in the same WAIT cycle: ack is ignored; rdy is honoured.
- downloading or loop_rst rising outside IDLE: the current transaction finishes normally; only new grants are blocked.
- rst mid-transaction: immediate return to reset values. sdram_req drops on the next edge; the controller is responsible for its own recovery.
- busy = (state ≠ IDLE).

Decomposition:
- Package jtframe_arb_pkg:
  - state enum {IDLE, REQ, WAIT, DONE}, 2 bits.
  - function rr_pick(req, ptr, n): returns index and a valid flag.
  - localparam for the grant index width, $clog2(NSLOT).
- Sub-module jtframe_rr_pick: combinational round-robin priority encoder. Inputs NSLOT requests and pointer; outputs grant index and valid. Reusable by other jtframe arbiters.

Test Plan:
- Single read: slot 2 requests addr 0x012345, ack after 2 cycles, rdy with data 0xDEADBEEF after 5 more → sdram_addr = 0x012345, sdram_rnw = 1, slot_ok = 4'b0100 for one cycle, slot_dout = 0xDEADBEEF; slots 0, 1 and 3 see no ok.
- Round-robin: all 4 slots request continuously with ack/rdy at fixed latency → grant order 0, 1, 2, 3, 0, 1; each slot_ok pulses once per 4 transactions.
- Write path: slot 1 with rnw = 0, wrmask = 2'b10, din = 0xA55A → sdram_rnw = 0, sdram_wrmask = 2'b10, data_write = 0xA55A held stable until rdy; slot_ok = 4'b0010.
- Gating: downloading = 1 while slot 0 requests → sdram_req stays 0 and busy = 0. Drop downloading → grant on the next edge. Raise downloading during WAIT → the current transaction still completes.
- Timeout: TOUT = 16, ack given, rdy never given → slot_err pulses 16 cycles after ack, state returns to IDLE, the next pending slot is granted.
- Reset mid-WAIT: assert rst for 1 cycle → sdram_req, slot_ok and busy = 0; pointer = 0; the re-issued request from slot 3 is then granted normally.
